// File: rtl/piso_shift_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : piso_shift_tx_if
//  Purpose  : Bundles the signals of the parallel-in/serial-out transmitter.
//             The load side is a valid/ready handshake. The serial side is
//             sout with its valid, last and busy qualifiers.
//  Modports : master - word source and serial sink (drives load_valid/data)
//             slave  - the transmitter (drives load_ready and the serial side)
//  Signals  : load_valid, load_ready, load_data[WIDTH], sout, sout_valid,
//             last, busy
//  Revision : 1.0  initial release
// ============================================================================
interface piso_shift_tx_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             sout;
   logic             sout_valid;
   logic             last;
   logic             busy;

   modport master (
      output load_valid, load_data,
      input  load_ready, sout, sout_valid, last, busy
   );

   modport slave (
      input  load_valid, load_data,
      output load_ready, sout, sout_valid, last, busy
   );
endinterface
`default_nettype wire

// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module   : piso_shift_tx
//  Purpose  : Parallel-in/serial-out shift transmitter. It accepts a WIDTH-bit
//             word over a valid/ready handshake and emits the word one bit per
//             clock. Words can follow each other with no idle cycle between
//             them.
//  Ports    : clk   - rising-edge clock
//             rst   - synchronous reset, active-high
//             io_tx - piso_shift_tx_if.slave (load handshake + serial output)
//  Params   : WIDTH (>=2) bits per word; MSB_FIRST 1 = bit WIDTH-1 first
//  Revision : 1.0  initial release
// ============================================================================
module piso_shift_tx #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  wire logic         clk,
   input  wire logic         rst,
   piso_shift_tx_if.slave    io_tx
);

   localparam int                c_CNT_W   = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_shreg;
   logic [WIDTH-1:0]   w_shreg_nxt;
   logic [WIDTH-1:0]   w_shifted;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic               w_out_bit;
   logic               w_load_ready;
   logic               w_accept;
   logic               w_sout_valid;
   logic               w_cnt_zero;

   // The output end of the shift register depends on the bit order; vacated
   // positions fill with zero.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
         assign w_out_bit = r_shreg[WIDTH-1];
      end else begin : g_lsb_first
         assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
         assign w_out_bit = r_shreg[0];
      end
   endgenerate

   assign w_cnt_zero   = (r_cnt == '0);
   assign w_sout_valid = (r_state == S_SHIFT);

   // A new word can be taken while idle or during the final bit of the
   // current word, which gives back-to-back transfers. Reset blocks it.
   assign w_load_ready = ~rst & ((r_state == S_IDLE) | w_cnt_zero);
   assign w_accept     = io_tx.load_valid & w_load_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_SHIFT;
               w_shreg_nxt = io_tx.load_data;
               w_cnt_nxt   = c_CNT_MAX;
            end
         end
         S_SHIFT: begin
            if (!w_cnt_zero) begin
               w_shreg_nxt = w_shifted;
               w_cnt_nxt   = r_cnt - c_CNT_ONE;
            end else if (w_accept) begin
               w_shreg_nxt = io_tx.load_data;
               w_cnt_nxt   = c_CNT_MAX;
            end else begin
               w_state_nxt = S_IDLE;
               w_shreg_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The serial outputs come from registered state only. sout is forced low
   // whenever no word is in flight.
   assign io_tx.load_ready = w_load_ready;
   assign io_tx.sout_valid = w_sout_valid;
   assign io_tx.sout       = w_sout_valid & w_out_bit;
   assign io_tx.last       = w_sout_valid & w_cnt_zero;
   assign io_tx.busy       = w_sout_valid;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_shift_tx
//  Purpose  : Testbench for piso_shift_tx. Two instances receive identical
//             stimulus, one sending MSB first and one sending LSB first. On
//             each accepted word, a word-level reference model pushes the
//             expected bit stream into per-instance queues. A monitor on the
//             falling edge pops those queues and compares them against the
//             serial outputs and load_ready.
//  Revision : 1.0  initial release
// ============================================================================
module tb_piso_shift_tx;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         tb_lv;
   logic [W-1:0] tb_data;

   int n_tests = 0;
   int n_fail  = 0;

   piso_shift_tx_if #(.WIDTH(W)) m_if ();
   piso_shift_tx_if #(.WIDTH(W)) l_if ();

   piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk   (clk),
      .rst   (rst),
      .io_tx (m_if.slave)
   );

   piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk   (clk),
      .rst   (rst),
      .io_tx (l_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Each queue entry is {expected bit, expected last}.
   logic [1:0] q_m[$];
   logic [1:0] q_l[$];
   int         bits_left = 0;   // bits of the current word not yet finished
   bit         seen_edge = 1'b0;

   always @(posedge clk) begin
      bit acc;
      seen_edge = 1'b1;
      if (rst) begin
         bits_left = 0;
         q_m.delete();
         q_l.delete();
      end else begin
         acc = tb_lv && (bits_left <= 1);
         if (bits_left > 0) bits_left--;
         if (acc) begin
            for (int i = 0; i < W; i++) begin
               q_m.push_back({tb_data[W-1-i], (i == W-1)});
               q_l.push_back({tb_data[i],     (i == W-1)});
            end
            bits_left = W;
         end
      end
   end

   // ---------------- monitor ----------------
   task automatic chk(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic       ev;
      logic [1:0] e;
      logic       er;
      if (seen_edge) begin
         er = !rst && (bits_left <= 1);

         ev = (q_m.size() > 0);
         e  = ev ? q_m.pop_front() : 2'b00;
         chk("msb_valid", m_if.sout_valid, ev);
         chk("msb_sout",  m_if.sout,       e[1]);
         chk("msb_last",  m_if.last,       e[0]);
         chk("msb_busy",  m_if.busy,       ev);
         chk("msb_ready", m_if.load_ready, er);

         ev = (q_l.size() > 0);
         e  = ev ? q_l.pop_front() : 2'b00;
         chk("lsb_valid", l_if.sout_valid, ev);
         chk("lsb_sout",  l_if.sout,       e[1]);
         chk("lsb_last",  l_if.last,       e[0]);
         chk("lsb_busy",  l_if.busy,       ev);
         chk("lsb_ready", l_if.load_ready, er);
      end
   end

   // ---------------- stimulus ----------------
   // Drives the inputs shortly after a rising edge and holds them across n edges.
   task automatic step(input logic r, input logic v, input logic [W-1:0] d, input int n);
      rst             = r;
      tb_lv           = v;
      tb_data         = d;
      m_if.load_valid = v;
      m_if.load_data  = d;
      l_if.load_valid = v;
      l_if.load_data  = d;
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      step(1'b1, 1'b0, 8'h00, 2);

      // single word from idle
      step(1'b0, 1'b1, 8'hA5, 1);
      step(1'b0, 1'b0, 8'h00, 10);

      // back-to-back: second word offered during the last bit of the first
      step(1'b0, 1'b1, 8'hA5, 1);
      step(1'b0, 1'b0, 8'h00, 7);
      step(1'b0, 1'b1, 8'h3C, 1);
      step(1'b0, 1'b0, 8'h00, 10);

      // bit-order patterns
      step(1'b0, 1'b1, 8'h01, 1);
      step(1'b0, 1'b0, 8'h00, 9);
      step(1'b0, 1'b1, 8'h80, 1);
      step(1'b0, 1'b0, 8'h00, 9);

      // offer during bit 3 of a word is ignored
      step(1'b0, 1'b1, 8'h00, 1);
      step(1'b0, 1'b0, 8'h00, 2);
      step(1'b0, 1'b1, 8'hFF, 1);
      step(1'b0, 1'b0, 8'h00, 10);

      // reset during bit 4 aborts the word, then a fresh word
      step(1'b0, 1'b1, 8'hA5, 1);
      step(1'b0, 1'b0, 8'h00, 3);
      step(1'b1, 1'b0, 8'h00, 1);
      step(1'b0, 1'b1, 8'h3C, 1);
      step(1'b0, 1'b0, 8'h00, 10);

      // reset held with valid asserted
      step(1'b1, 1'b1, 8'hFF, 5);
      step(1'b0, 1'b0, 8'h00, 2);

      // randomized traffic
      repeat (500) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
              W'($urandom), 1);
      end

      step(1'b0, 1'b0, 8'h00, W + 3);
      @(negedge clk);
      #1;
      chk("drain_msb", (q_m.size() == 0), 1'b1);
      chk("drain_lsb", (q_l.size() == 0), 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
